// File: rtl/ckt_3bit_input.sv
// ckt_3bit_input: registered relation checker for two 3-bit operands.
// Each rising edge samples a and b and registers five flags:
// Gray-code match, excess-3 match, unsigned greater/less, and
// "no code relation". Outputs are registered only, so there is no
// combinational path from the operands to the flags.

module ckt_3bit_input #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gray,
    output logic         excess_3,
    output logic         more,
    output logic         less,
    output logic         no_relation
);

    // Reflected binary Gray code of a binary value.
    function automatic logic [W-1:0] gray_code(input logic [W-1:0] value);
        return value ^ (value >> 1);
    endfunction

    // Excess-3 code; the sum is truncated to W bits, so 5..7 wrap to 0..2.
    function automatic logic [W-1:0] excess3_code(input logic [W-1:0] value);
        logic [W-1:0] three;
        three = W'(3);
        return value + three;
    endfunction

    logic gray_next;
    logic excess_3_next;
    logic more_next;
    logic less_next;
    logic no_relation_next;

    // Evaluate every relation for the operands currently on the inputs.
    // NOTE: each signal gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        gray_next        = 1'b0;
        excess_3_next    = 1'b0;
        more_next        = 1'b0;
        less_next        = 1'b0;
        no_relation_next = 1'b0;

        gray_next        = (b == gray_code(a));
        excess_3_next    = (b == excess3_code(a));
        more_next        = (a > b);
        less_next        = (a < b);
        no_relation_next = !(gray_next || excess_3_next);
    end

    // Register the flags; reset wins over the sampled operands.
    // NOTE: state is updated with non-blocking assignments so every flag
    // captures values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray        <= 1'b0;
            excess_3    <= 1'b0;
            more        <= 1'b0;
            less        <= 1'b0;
            no_relation <= 1'b0;
        end else begin
            gray        <= gray_next;
            excess_3    <= excess_3_next;
            more        <= more_next;
            less        <= less_next;
            no_relation <= no_relation_next;
        end
    end

endmodule

// File: tb/tb_ckt_3bit_input.sv
// tb_ckt_3bit_input: directed self-checking bench for ckt_3bit_input.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Expected flags are packed as
// {gray, excess_3, more, less, no_relation}.

module tb_ckt_3bit_input;

    logic       clk;
    logic       rst;
    logic [2:0] a;
    logic [2:0] b;
    logic       gray;
    logic       excess_3;
    logic       more;
    logic       less;
    logic       no_relation;

    int checks;
    int errors;

    // Gray codes of 0..7 written out by hand.
    logic [2:0] gray_table [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                   3'b110, 3'b111, 3'b101, 3'b100};

    ckt_3bit_input #(.W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .gray        (gray),
        .excess_3    (excess_3),
        .more        (more),
        .less        (less),
        .no_relation (no_relation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {gray, excess_3, more, less, no_relation};
    endfunction

    task automatic check(input string tag, input logic [4:0] observed,
                         input logic [4:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge, then wait for the sampling edge.
    task automatic step(input logic r, input logic [2:0] av, input logic [2:0] bv);
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] model(input logic [2:0] av, input logic [2:0] bv);
        logic [3:0] sum;
        logic       g, e;
        sum = {1'b0, av} + 4'd3;
        g   = (bv == gray_table[av]);
        e   = (bv == sum[2:0]);
        return {g, e, (av > bv), (av < bv), !(g || e)};
    endfunction

    initial begin
        logic [4:0] held;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = 3'b111;
        b   = 3'b100;

        // Reset held for two edges with live operands on the inputs.
        step(1'b1, 3'b111, 3'b100);
        check("reset_edge1", flags(), 5'b00000);
        step(1'b1, 3'b111, 3'b100);
        check("reset_edge2", flags(), 5'b00000);

        // First non-reset edge: 111 -> gray 100.
        step(1'b0, 3'b111, 3'b100);
        check("post_reset_gray", flags(), 5'b10100);

        step(1'b0, 3'b010, 3'b011);
        check("gray_less", flags(), 5'b10010);

        // Outputs hold between edges even when inputs change.
        held = flags();
        #2;
        a = 3'b000;
        b = 3'b111;
        #1;
        check("hold_between_edges", flags(), held);

        step(1'b0, 3'b101, 3'b010);
        check("no_rel_more_a", flags(), 5'b00101);
        step(1'b0, 3'b101, 3'b100);
        check("no_rel_more_b", flags(), 5'b00101);

        step(1'b0, 3'b001, 3'b100);
        check("ex3_less", flags(), 5'b01010);
        step(1'b0, 3'b110, 3'b001);
        check("ex3_wrap", flags(), 5'b01100);

        step(1'b0, 3'b011, 3'b011);
        check("equal_no_rel", flags(), 5'b00001);
        step(1'b0, 3'b001, 3'b110);
        check("less_no_rel", flags(), 5'b00011);

        // Exhaustive sweep with one reset cycle in the middle.
        for (int i = 0; i < 64; i++) begin
            logic [2:0] av, bv;
            av = 3'(i >> 3);
            bv = 3'(i);
            if (i == 30) begin
                step(1'b1, av, bv);
                check("mid_sweep_reset", flags(), 5'b00000);
            end
            step(1'b0, av, bv);
            check($sformatf("sweep_a%0d_b%0d", av, bv), flags(), model(av, bv));
            check("gray_ex3_exclusive", {4'b0000, gray && excess_3}, 5'b00000);
            check("more_less_exclusive", {4'b0000, more && less}, 5'b00000);
        end

        // Reset cleared only one edge; the next edge resumes normal results.
        step(1'b0, 3'b111, 3'b010);
        check("after_sweep_ex3", flags(), 5'b01100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ckt_3bit_input.md
Name: ckt_3bit_input

Overview:
- Registered 3-bit operand relation checker for the datapath compare stage.
- Samples two 3-bit operands a and b each clock and flags their relationship:
  - b is the Gray code of a
  - b is the excess-3 code of a
  - a greater than b
  - a less than b
  - none of the code relations holds
- All flags are registered outputs driven from one clock domain.

Parameters:
- W, 3, operand width in bits; only W=3 is required to be supported, other values are out of scope.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  3  first operand (binary value).
- b  input  3  second operand (candidate code word / comparand).
- gray  output  1  1 when b equals Gray code of a.
- excess_3  output  1  1 when b equals excess-3 code of a.
- more  output  1  1 when a > b (unsigned).
- less  output  1  1 when a < b (unsigned).
- no_relation  output  1  1 when neither gray nor excess_3 relation holds.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - On a rising clk edge with rst=1, all five outputs are cleared to 0.
  - rst takes priority over the sampled a/b values.
  - While rst is held, all outputs stay 0.
- Latency:
  - Outputs are registered, one-cycle latency.
  - a and b sampled at rising edge N drive the outputs from edge N until edge N+1.
  - No combinational path from inputs to outputs.
- No handshake:
  - A new evaluation happens every cycle.
  - Outputs hold until the next edge.
- Gray relation:
  - gray_code(a) = a XOR (a >> 1), 3 bits.
  - gray = (b == gray_code(a)).
  - Full mapping a -> code: 000->000, 001->001, 010->011, 011->010, 100->110, 101->111, 110->101, 111->100.
- Excess-3 relation:
  - ex3(a) = (a + 3) truncated to 3 bits; wraps modulo 8.
  - 101->000, 110->001, 111->010.
  - excess_3 = (b == ex3(a)).
- Magnitude compare:
  - Unsigned.
  - more = (a > b); less = (a < b).
  - a == b gives more=0, less=0.
  - more and less are never 1 simultaneously.
- no_relation = NOT(gray OR excess_3), computed from the same sampled operands. It is independent of more/less.
- gray and excess_3 are both 1 only when gray_code(a) == ex3(a). No 3-bit a satisfies this, so a bench asserts they are never both 1.
- After reset deassertion, the first sampled result appears after the first non-reset edge.
- Reset asserted mid-stream clears the outputs at that edge; the pending operands are discarded.

Test Plan:
1. rst=1 for 2 cycles with a=111, b=100 -> all outputs 0; release rst -> next edge gray=1, excess_3=0, more=1, less=0, no_relation=0.
2. a=010, b=011 -> gray=1, excess_3=0, more=0, less=1, no_relation=0.
3. a=101, b=010 -> gray=0, excess_3=0, more=1, less=0, no_relation=1; then a=101, b=100 -> gray=0, excess_3=0, more=1, less=0, no_relation=1.
4. a=001, b=100 -> excess_3=1, gray=0, less=1, more=0, no_relation=0; a=110, b=001 (wrap) -> excess_3=1, more=1, no_relation=0.
5. a=011, b=011 -> gray=0, excess_3=0, more=0, less=0, no_relation=1; then a=001, b=110 -> less=1, no_relation=1.
6. Exhaustive sweep of all 64 (a,b) pairs against a reference model, with outputs checked one cycle after application:
   - gray and excess_3 never both 1.
   - more and less never both 1.
   - Assert rst on one mid-sweep cycle -> all outputs 0 on that edge only.
